// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory initiators:
// FSM states, command op encodings and default widths.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic OP_COPY = 1'b0;
   localparam logic OP_FILL = 1'b1;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   localparam int LEN_W_DEF  = 6;

endpackage

// File: rtl/mem_addr_gen.sv
// Source/destination word pointers and remaining-word count.
// Ports: load latches start addresses, step advances, last flags final word.
module mem_addr_gen #(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic              descending,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  len,
   output logic [ADDR_W-1:0] src_cur,
   output logic [ADDR_W-1:0] dst_cur,
   output logic              last
);

   logic [ADDR_W-1:0] span;
   logic [LEN_W-1:0]  rem_q;
   logic              desc_q;

   // Offset of the final word; descending copies start there.
   assign span = {{(ADDR_W-LEN_W){1'b0}}, len} - ADDR_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         src_cur <= '0;
         dst_cur <= '0;
         rem_q   <= '0;
         desc_q  <= 1'b0;
      end else if (load) begin
         desc_q  <= descending;
         rem_q   <= len;
         src_cur <= descending ? src_addr + span : src_addr;
         dst_cur <= descending ? dst_addr + span : dst_addr;
      end else if (step) begin
         rem_q <= rem_q - LEN_W'(1);
         if (desc_q) begin
            src_cur <= src_cur - ADDR_W'(1);
            dst_cur <= dst_cur - ADDR_W'(1);
         end else begin
            src_cur <= src_cur + ADDR_W'(1);
            dst_cur <= dst_cur + ADDR_W'(1);
         end
      end
   end

   assign last = (rem_q == LEN_W'(1));

endmodule

// File: rtl/mem_copy_engine.sv
// Block copy / fill master for the single-port data memory.
// Ports: start/op/src/dst/len/fill command in; busy/done/words_done status; mem port.
module mem_copy_engine
   import mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              op,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  len,
   input  logic [DATA_W-1:0] fill_data,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  words_done,
   output logic              memwrite,
   output logic              memread,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] write_data,
   input  logic [DATA_W-1:0] read_data
);

   state_t            state_q;
   state_t            state_d;
   logic              op_q;
   logic [DATA_W-1:0] fill_q;
   logic [LEN_W-1:0]  wd_q;
   logic              accept;
   logic [ADDR_W:0]   src_end;
   logic              overlap;
   logic              descending;
   logic [ADDR_W-1:0] src_cur;
   logic [ADDR_W-1:0] dst_cur;
   logic              last;

   assign accept = (state_q == IDLE) && start;

   // A destination starting inside the source block would clobber
   // unread words going upward, so such copies run top-down.
   assign src_end = {1'b0, src_addr}
                  + {{(ADDR_W+1-LEN_W){1'b0}}, len};
   assign overlap = ({1'b0, dst_addr} > {1'b0, src_addr})
                 && ({1'b0, dst_addr} < src_end);
   assign descending = (op == OP_COPY) && overlap;

   mem_addr_gen #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_addr (
      .clk        (clk),
      .rst        (rst),
      .load       (accept),
      .step       (state_q == WR),
      .descending (descending),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .len        (len),
      .src_cur    (src_cur),
      .dst_cur    (dst_cur),
      .last       (last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= OP_COPY;
         fill_q  <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q   <= op;
            fill_q <= fill_data;
            wd_q   <= '0;
         end else if (state_q == WR) begin
            wd_q <= wd_q + LEN_W'(1);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (len == '0)
                  state_d = DONE;
               else if (op == OP_COPY)
                  state_d = RD;
               else
                  state_d = WR;
            end
         end
         RD: state_d = WR;
         WR: begin
            if (last)
               state_d = DONE;
            else if (op_q == OP_COPY)
               state_d = RD;
            else
               state_d = WR;
         end
         DONE: state_d = IDLE;
      endcase
   end

   always_comb begin
      memread    = 1'b0;
      memwrite   = 1'b0;
      address    = '0;
      write_data = '0;
      unique case (1'b1)
         (state_q == RD): begin
            memread = 1'b1;
            address = src_cur;
         end
         (state_q == WR): begin
            memwrite   = 1'b1;
            address    = dst_cur;
            write_data = (op_q == OP_FILL) ? fill_q : read_data;
         end
         default: ;
      endcase
   end

   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign words_done = wd_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Randomized bench for mem_copy_engine against a behavioural trace model.
// Includes a 256-word memory responder and directed corner cases.
module tb_mem_copy_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        op;
   logic [31:0] src_addr;
   logic [31:0] dst_addr;
   logic [5:0]  len;
   logic [31:0] fill_data;
   logic        busy;
   logic        done;
   logic [5:0]  words_done;
   logic        memwrite;
   logic        memread;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;

   always #5 clk = ~clk;

   mem_copy_engine dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .op         (op),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .len        (len),
      .fill_data  (fill_data),
      .busy       (busy),
      .done       (done),
      .words_done (words_done),
      .memwrite   (memwrite),
      .memread    (memread),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data)
   );

   typedef struct {
      logic        busy;
      logic        done;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [5:0]  wd;
   } exp_t;

   exp_t        q[$];
   logic [5:0]  wd_idle;
   bit          chk_en;
   int          total;
   int          bad;
   logic [31:0] mem[256];
   logic [31:0] expm[256];
   int          mlog[$];

   task automatic chk(input string nm,
                      input logic [63:0] a,
                      input logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t",
                  nm, a, e, $time);
      end
   endtask

   function automatic exp_t mk(input logic b, input logic d,
                               input logic r, input logic w,
                               input logic [31:0] a,
                               input logic [31:0] x,
                               input logic [5:0] n);
      exp_t e;
      e.busy = b; e.done = d; e.rd = r; e.wr = w;
      e.addr = a; e.wdata = x; e.wd = n;
      return e;
   endfunction

   // memory responder: registered read, held until next read
   initial read_data = '0;
   always @(posedge clk) begin
      if (memwrite) mem[address[7:0]] <= write_data;
      if (memread) read_data <= mem[address[7:0]];
      if (memread || memwrite) mlog.push_back(int'(address));
   end

   // per-cycle compare against the model trace
   always @(negedge clk) begin : cmp
      exp_t e;
      if (chk_en) begin
         if (q.size() > 0) e = q.pop_front();
         else e = mk(0, 0, 0, 0, 0, 0, wd_idle);
         chk("busy", 64'(busy), 64'(e.busy));
         chk("done", 64'(done), 64'(e.done));
         chk("memread", 64'(memread), 64'(e.rd));
         chk("memwrite", 64'(memwrite), 64'(e.wr));
         chk("address", 64'(address), 64'(e.addr));
         chk("words_done", 64'(words_done), 64'(e.wd));
         chk("rd_wr_excl", 64'(memread & memwrite), 64'd0);
         if (e.wr)
            chk("write_data", 64'(write_data), 64'(e.wdata));
      end
   end

   // abort_wr>0: rst during the RD that follows that many WRs
   task automatic run_cmd(input logic o, input logic [31:0] s,
                          input logic [31:0] d,
                          input logic [5:0] n,
                          input logic [31:0] f,
                          input int abort_wr,
                          input int restart_at);
      logic [31:0] orig[256];
      exp_t        tr[$];
      logic [32:0] s_end;
      bit          desc;
      int          lim;
      logic [31:0] sk, dk, x;
      int          g;
      @(negedge clk);
      mlog.delete();
      foreach (mem[i]) begin
         orig[i] = mem[i];
         expm[i] = mem[i];
      end
      op = o; src_addr = s; dst_addr = d; len = n;
      fill_data = f; start = 1'b1;
      s_end = {1'b0, s} + 33'(n);
      desc = (o == 1'b0) && ({1'b0, d} > {1'b0, s})
          && ({1'b0, d} < s_end);
      lim = (abort_wr > 0) ? abort_wr : int'(n);
      for (int k = 0; k < int'(n); k++) begin
         sk = desc ? s + 32'(n) - 1 - 32'(k) : s + 32'(k);
         dk = desc ? d + 32'(n) - 1 - 32'(k) : d + 32'(k);
         x = o ? f : orig[sk[7:0]];
         if (!o) tr.push_back(mk(1, 0, 1, 0, sk, 0, 6'(k)));
         tr.push_back(mk(1, 0, 0, 1, dk, x, 6'(k)));
         if (k < lim) expm[dk[7:0]] = x;
      end
      tr.push_back(mk(1, 1, 0, 0, 0, 0, n));
      if (abort_wr > 0) begin
         while (tr.size() > 2 * abort_wr + 1) void'(tr.pop_back());
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      src_addr = $urandom; dst_addr = $urandom;
      len = 6'($urandom); fill_data = $urandom;
      op = 1'($urandom);
      wd_idle = (abort_wr > 0) ? 6'd0 : n;
      foreach (tr[i]) q.push_back(tr[i]);
      if (abort_wr > 0) begin
         repeat (2 * abort_wr) @(posedge clk);
         #1 rst = 1'b1;
         @(posedge clk);
         #1 rst = 1'b0;
      end
      if (restart_at > 0) begin
         repeat (restart_at) @(posedge clk);
         #1;
         start = 1'b1; dst_addr = d + 32'd40;
         @(posedge clk);
         #1 start = 1'b0;
      end
      g = 0;
      while (q.size() > 0 && g < 400) begin
         @(posedge clk);
         g++;
      end
      chk("trace_drain", 64'(q.size()), 64'd0);
      q.delete();
      @(negedge clk);
      @(negedge clk);
      g = -1;
      foreach (mem[i]) if (g < 0 && mem[i] !== expm[i]) g = i;
      chk("mem_image_first_bad", 64'(g), 64'hFFFF_FFFF_FFFF_FFFF);
   endtask

   task automatic chk_log(input string nm, input int e[$]);
      chk({nm, "_len"}, 64'(mlog.size()), 64'(e.size()));
      foreach (e[i]) begin
         if (i < mlog.size())
            chk(nm, 64'(mlog[i]), 64'(e[i]));
      end
   endtask

   initial begin
      int el[$];
      logic [31:0] s, d;
      rst = 1'b1; start = 1'b0; op = 1'b0;
      src_addr = '0; dst_addr = '0; len = '0; fill_data = '0;
      wd_idle = '0; chk_en = 1'b0; total = 0; bad = 0;
      foreach (mem[i]) mem[i] <= $urandom;
      @(posedge clk);
      #1 chk_en = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;

      mem[7] <= 32'h77;
      run_cmd(1'b1, 32'd0, 32'd4, 6'd3, 32'hDEADBEEF, 0, 0);
      el = '{4, 5, 6};
      chk_log("fill_addrs", el);
      chk("fill_w4", 64'(mem[4]), 64'hDEADBEEF);
      chk("fill_w6", 64'(mem[6]), 64'hDEADBEEF);
      chk("fill_w7", 64'(mem[7]), 64'h77);

      for (int i = 0; i < 4; i++) mem[i] <= 32'(i + 1);
      run_cmd(1'b0, 32'd0, 32'd8, 6'd4, 32'h0, 0, 0);
      el = '{0, 8, 1, 9, 2, 10, 3, 11};
      chk_log("copy_addrs", el);
      chk("copy_w11", 64'(mem[11]), 64'd4);
      chk("copy_wd", 64'(words_done), 64'd4);

      for (int i = 0; i < 4; i++) mem[i] <= 32'(10 + i);
      run_cmd(1'b0, 32'd0, 32'd2, 6'd4, 32'h0, 0, 0);
      el = '{3, 5, 2, 4, 1, 3, 0, 2};
      chk_log("ovl_addrs", el);
      chk("ovl_w2", 64'(mem[2]), 64'hA);
      chk("ovl_w5", 64'(mem[5]), 64'hD);

      run_cmd(1'b0, 32'd20, 32'd30, 6'd0, 32'h0, 0, 0);
      chk("len0_nomem", 64'(mlog.size()), 64'd0);

      run_cmd(1'b1, 32'd0, 32'd50, 6'd5, 32'h1234_5678, 0, 2);
      chk("restart_w90", 64'(mem[90]), 64'(expm[90]));

      run_cmd(1'b0, 32'd100, 32'd140, 6'd6, 32'h0, 3, 0);
      chk("abort_w143", 64'(mem[143]), 64'(expm[143]));
      chk("abort_wd", 64'(words_done), 64'd0);
      run_cmd(1'b1, 32'd0, 32'd60, 6'd4, 32'hCAFE_F00D, 0, 0);

      run_cmd(1'b0, 32'd70, 32'd70, 6'd5, 32'h0, 0, 0);

      for (int t = 0; t < 30; t++) begin
         s = 32'($urandom_range(10, 150));
         if ($urandom_range(0, 1) == 1)
            d = s + 32'($urandom_range(0, 8)) - 32'd4;
         else
            d = 32'($urandom_range(0, 160));
         run_cmd(1'($urandom), s, d,
                 6'($urandom_range(0, 40)), $urandom, 0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
